// File: rtl/dut_vector_engine_pkg.sv
// Shared definitions for the vector engine: FSM state codes, mode codes and
// helpers that locate fields inside the stimulus and result FIFO words.
//   sfifo entry : {last, cycles, expected, stim}   (stim at bit 0)
//   rfifo entry : {mismatch, cycles, sample}       (sample at bit 0)
package dut_vector_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_APPLY  = 3'd2;
  localparam logic [STATE_W-1:0] ST_SAMPLE = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

  localparam logic MODE_CAPTURE = 1'b0;
  localparam logic MODE_COMPARE = 1'b1;

  // Default geometry, used where no override is given
  localparam int unsigned DEF_STF_WIDTH   = 24;
  localparam int unsigned DEF_RTF_WIDTH   = 24;
  localparam int unsigned DEF_CYCLE_RANGE = 5;

  function automatic int unsigned sf_width(input int unsigned stf, input int unsigned rtf,
                                           input int unsigned cr);
    return 1 + (cr + 1) + rtf + stf;
  endfunction

  function automatic int unsigned rf_width(input int unsigned rtf, input int unsigned cr);
    return 1 + (cr + 1) + rtf;
  endfunction

  // Stimulus-entry field offsets
  function automatic int unsigned sf_exp_lsb(input int unsigned stf);
    return stf;
  endfunction

  function automatic int unsigned sf_cyc_lsb(input int unsigned stf, input int unsigned rtf);
    return stf + rtf;
  endfunction

  // Result-entry field offsets
  function automatic int unsigned rf_cyc_lsb(input int unsigned rtf);
    return rtf;
  endfunction

  localparam int unsigned DEF_SFW = 1 + (DEF_CYCLE_RANGE + 1) + DEF_RTF_WIDTH + DEF_STF_WIDTH;
  localparam int unsigned DEF_RFW = 1 + (DEF_CYCLE_RANGE + 1) + DEF_RTF_WIDTH;

endpackage

// File: rtl/dut_vector_engine_if.sv
// FIFO-side bus of the vector engine: show-ahead stimulus FIFO read port and
// result FIFO write port.
//   master : engine side (pops stimulus, pushes results)
//   slave  : FIFO side
interface dut_vector_engine_if
  import dut_vector_pkg::*;
#(
  parameter int unsigned SFW = DEF_SFW,
  parameter int unsigned RFW = DEF_RFW
);
  logic [SFW-1:0] sfifo_data;
  logic           sfifo_rdempty;
  logic           sfifo_rdreq;
  logic [RFW-1:0] rfifo_data;
  logic           rfifo_wrreq;
  logic           rfifo_wrfull;

  modport master (
    input  sfifo_data, sfifo_rdempty, rfifo_wrfull,
    output sfifo_rdreq, rfifo_data, rfifo_wrreq
  );

  modport slave (
    output sfifo_data, sfifo_rdempty, rfifo_wrfull,
    input  sfifo_rdreq, rfifo_data, rfifo_wrreq
  );
endinterface

// File: rtl/dut_vector_engine_lane_mux.sv
// dut_lane_mux: registered NUM_DUT:1 selector over the concatenated miso lanes.
// Captures the selected lane when en is high; an index >= NUM_DUT yields 0.
//   clk, rst_n : clock, async active-low reset
//   en         : capture strobe
//   sel        : lane index
//   miso       : lane k at [k*RTF_WIDTH +: RTF_WIDTH]
//   sample     : registered lane value
module dut_lane_mux #(
  parameter int unsigned NUM_DUT   = 4,
  parameter int unsigned RTF_WIDTH = 24,
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic [NUM_DUT*RTF_WIDTH-1:0] miso,
  output logic [RTF_WIDTH-1:0]         sample
);

  logic [RTF_WIDTH-1:0] pick_c;

  // Indices with no matching lane fall through to the zero default
  always_comb begin
    pick_c = '0;
    for (int k = 0; k < int'(NUM_DUT); k++) begin
      if (sel == SEL_WIDTH'(k)) pick_c = miso[k*RTF_WIDTH +: RTF_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  sample <= '0;
    else if (en) sample <= pick_c;
  end

endmodule

// File: rtl/dut_vector_engine.sv
// dut_vector_engine: pulls vectors from a show-ahead stimulus FIFO, drives them
// on mosi for a per-vector hold count, samples one miso lane, optionally
// compares it under a mask and pushes a result word to the result FIFO.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   start, abort            : run control (abort has priority)
//   mode, lane_sel, cmp_mask: run configuration, latched on start
//   fifo (master)           : stimulus/result FIFO bus
//   mosi / miso             : broadcast stimulus / per-lane responses
//   target_sel, busy, done  : status
//   fail, fail_count, vec_count : run results, held until next start
// Build option: VECTOR_ENGINE_STOP_ON_FAIL_EN ends a COMPARE run after the
// first mismatching vector has been written.
module dut_vector_engine
  import dut_vector_pkg::*;
#(
  parameter int unsigned STF_WIDTH   = 24,
  parameter int unsigned RTF_WIDTH   = 24,
  parameter int unsigned CYCLE_RANGE = 5,
  parameter int unsigned NUM_DUT     = 4,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         lane_sel,
  input  logic [RTF_WIDTH-1:0]         cmp_mask,
  dut_vector_engine_if.master          fifo,
  output logic [STF_WIDTH-1:0]         mosi,
  input  logic [NUM_DUT*RTF_WIDTH-1:0] miso,
  output logic [SEL_WIDTH-1:0]         target_sel,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic [CNT_WIDTH-1:0]         fail_count,
  output logic [CNT_WIDTH-1:0]         vec_count
);

  localparam int unsigned CYC_W      = CYCLE_RANGE + 1;
  localparam int unsigned SFW        = sf_width(STF_WIDTH, RTF_WIDTH, CYCLE_RANGE);
  localparam int unsigned RFW        = rf_width(RTF_WIDTH, CYCLE_RANGE);
  localparam int unsigned SF_EXP_LSB = sf_exp_lsb(STF_WIDTH);
  localparam int unsigned SF_CYC_LSB = sf_cyc_lsb(STF_WIDTH, RTF_WIDTH);
  localparam int unsigned SF_LAST    = SFW - 1;
  localparam int unsigned RF_CYC_LSB = rf_cyc_lsb(RTF_WIDTH);
  localparam int unsigned RF_MIS     = RFW - 1;

  logic [STATE_W-1:0]   state_q,   state_nx;
  logic                 mode_q,    mode_nx;
  logic [RTF_WIDTH-1:0] mask_q,    mask_nx;
  logic [SEL_WIDTH-1:0] sel_nx;
  logic [STF_WIDTH-1:0] mosi_nx;
  logic [RTF_WIDTH-1:0] exp_q,     exp_nx;
  logic [CYC_W-1:0]     cyc_q,     cyc_nx;
  logic                 last_q,    last_nx;
  logic [CYC_W-1:0]     hold_q,    hold_nx;
  logic                 rdreq_q,   rdreq_nx;
  logic                 wrreq_q,   wrreq_nx;
  logic [RFW-1:0]       rdata_q,   rdata_nx;
  logic                 busy_nx,   done_nx,  fail_nx;
  logic [CNT_WIDTH-1:0] fcnt_nx,   vcnt_nx;
  logic                 mis_c;
  logic                 cap_en_c;
  logic [RTF_WIDTH-1:0] sample;

  assign fifo.sfifo_rdreq = rdreq_q;
  assign fifo.rfifo_wrreq = wrreq_q;
  assign fifo.rfifo_data  = rdata_q;

  // Lane captured on the last APPLY edge, seen by SAMPLE the cycle after
  assign cap_en_c = (state_q == ST_APPLY) && (hold_q == '0);

  dut_lane_mux #(
    .NUM_DUT  (NUM_DUT),
    .RTF_WIDTH(RTF_WIDTH),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_lane_mux (
    .clk   (clock),
    .rst_n (reset_n),
    .en    (cap_en_c),
    .sel   (target_sel),
    .miso  (miso),
    .sample(sample)
  );

  assign mis_c = (mode_q == MODE_COMPARE) && (|((sample ^ exp_q) & mask_q));

  // Next-state and next-output logic
  always_comb begin
    state_nx = state_q;
    mode_nx  = mode_q;
    mask_nx  = mask_q;
    sel_nx   = target_sel;
    mosi_nx  = mosi;
    exp_nx   = exp_q;
    cyc_nx   = cyc_q;
    last_nx  = last_q;
    hold_nx  = hold_q;
    rdreq_nx = 1'b0;
    wrreq_nx = 1'b0;
    rdata_nx = rdata_q;
    fail_nx  = fail;
    fcnt_nx  = fail_count;
    vcnt_nx  = vec_count;

    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_nx  = mode;
            sel_nx   = lane_sel;
            mask_nx  = cmp_mask;
            fail_nx  = 1'b0;
            fcnt_nx  = '0;
            vcnt_nx  = '0;
            state_nx = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!fifo.sfifo_rdempty) begin
            rdreq_nx = 1'b1;
            mosi_nx  = fifo.sfifo_data[STF_WIDTH-1:0];
            exp_nx   = fifo.sfifo_data[SF_EXP_LSB +: RTF_WIDTH];
            cyc_nx   = fifo.sfifo_data[SF_CYC_LSB +: CYC_W];
            last_nx  = fifo.sfifo_data[SF_LAST];
            hold_nx  = fifo.sfifo_data[SF_CYC_LSB +: CYC_W];
            state_nx = ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (hold_q == '0) state_nx = ST_SAMPLE;
          else              hold_nx  = hold_q - CYC_W'(1);
        end
        ST_SAMPLE: begin
          rdata_nx = {mis_c, cyc_q, sample};
          state_nx = ST_WRITE;
        end
        ST_WRITE: begin
          if (!fifo.rfifo_wrfull) begin
            wrreq_nx = 1'b1;
            if (!(&vec_count)) vcnt_nx = vec_count + CNT_WIDTH'(1);
            if (rdata_q[RF_MIS]) begin
              fail_nx = 1'b1;
              if (!(&fail_count)) fcnt_nx = fail_count + CNT_WIDTH'(1);
            end
            state_nx = last_q ? ST_DONE : ST_LOAD;
`ifdef VECTOR_ENGINE_STOP_ON_FAIL_EN
            // Mismatch only ever set in COMPARE mode
            if (rdata_q[RF_MIS]) state_nx = ST_DONE;
`else
`endif
          end
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end

    done_nx = (state_nx == ST_DONE);
    busy_nx = (state_nx != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_CAPTURE;
      mask_q     <= '0;
      target_sel <= '0;
      mosi       <= '0;
      exp_q      <= '0;
      cyc_q      <= '0;
      last_q     <= 1'b0;
      hold_q     <= '0;
      rdreq_q    <= 1'b0;
      wrreq_q    <= 1'b0;
      rdata_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_count <= '0;
      vec_count  <= '0;
    end else begin
      state_q    <= state_nx;
      mode_q     <= mode_nx;
      mask_q     <= mask_nx;
      target_sel <= sel_nx;
      mosi       <= mosi_nx;
      exp_q      <= exp_nx;
      cyc_q      <= cyc_nx;
      last_q     <= last_nx;
      hold_q     <= hold_nx;
      rdreq_q    <= rdreq_nx;
      wrreq_q    <= wrreq_nx;
      rdata_q    <= rdata_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      fail       <= fail_nx;
      fail_count <= fcnt_nx;
      vec_count  <= vcnt_nx;
    end
  end

endmodule

// File: tb/tb_dut_vector_engine.sv
// Directed bench for dut_vector_engine with behavioural show-ahead stimulus
// FIFO and result FIFO. Lane 3 of miso carries a free-running edge index so
// the exact sampling edge can be read back from the result word.
module tb_dut_vector_engine;
  import dut_vector_pkg::*;

  localparam int unsigned STF = 24;
  localparam int unsigned RTF = 24;
  localparam int unsigned CR  = 5;
  localparam int unsigned ND  = 4;
  localparam int unsigned SW  = 2;
  localparam int unsigned CW  = 16;
  localparam int unsigned CYW = CR + 1;
  localparam int unsigned SFW = 1 + CYW + RTF + STF;
  localparam int unsigned RFW = 1 + CYW + RTF;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            mode = 1'b0;
  logic [SW-1:0]   lane_sel = '0;
  logic [RTF-1:0]  cmp_mask = '0;
  logic [STF-1:0]  mosi;
  logic [ND*RTF-1:0] miso;
  logic [SW-1:0]   target_sel;
  logic            busy, done, fail;
  logic [CW-1:0]   fail_count, vec_count;

  logic [RTF-1:0]  lane0_v = '0;
  logic [RTF-1:0]  lane1_v = '0;
  logic [RTF-1:0]  lane2_v = '0;
  int              edge_idx = 0;

  logic [SFW-1:0]  sq[$];
  logic [RFW-1:0]  rq[$];
  int              rd_idx[$];
  int              done_cnt = 0;
  int              viol = 0;
  logic            prev_rd = 1'b0;
  logic            prev_wr = 1'b0;

  int checks = 0;
  int errors = 0;

  dut_vector_engine_if #(.SFW(SFW), .RFW(RFW)) fifo_if ();

  assign miso = {edge_idx[RTF-1:0], lane2_v, lane1_v, lane0_v};

  dut_vector_engine #(
    .STF_WIDTH(STF), .RTF_WIDTH(RTF), .CYCLE_RANGE(CR),
    .NUM_DUT(ND), .SEL_WIDTH(SW), .CNT_WIDTH(CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .lane_sel  (lane_sel),
    .cmp_mask  (cmp_mask),
    .fifo      (fifo_if),
    .mosi      (mosi),
    .miso      (miso),
    .target_sel(target_sel),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_count(fail_count),
    .vec_count (vec_count)
  );

  always #5 clock = ~clock;

  // FIFO models, edge index and protocol monitor
  always @(posedge clock) begin
    edge_idx <= edge_idx + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (fifo_if.sfifo_rdreq) begin
      if (sq.size() == 0 || prev_rd) viol <= viol + 1;
      if (sq.size() != 0) begin
        rd_idx.push_back(edge_idx);
        void'(sq.pop_front());
      end
    end
    if (fifo_if.rfifo_wrreq) begin
      if (fifo_if.rfifo_wrfull || prev_wr) viol <= viol + 1;
      rq.push_back(fifo_if.rfifo_data);
    end
    prev_rd <= fifo_if.sfifo_rdreq;
    prev_wr <= fifo_if.rfifo_wrreq;
  end

  always @(negedge clock) begin
    fifo_if.sfifo_rdempty <= (sq.size() == 0);
    fifo_if.sfifo_data    <= (sq.size() != 0) ? sq[0] : '0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_vec(input logic last, input int c, input logic [RTF-1:0] e,
                          input logic [STF-1:0] s);
    sq.push_back({last, CYW'(c), e, s});
  endtask

  task automatic run_start(input logic m, input logic [SW-1:0] sel, input logic [RTF-1:0] mask);
    mode = m; lane_sel = sel; cmp_mask = mask;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  function automatic logic [RFW-1:0] res(input logic mis, input int c, input logic [RTF-1:0] s);
    return {mis, CYW'(c), s};
  endfunction

  initial begin
    int d0;
    int n;
    int cs[3];
    fifo_if.rfifo_wrfull = 1'b0;
    cs[0] = 0; cs[1] = 3; cs[2] = 31;

    // Reset state
    tick(3);
    check("rst_mosi",  64'(mosi), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_fail",  64'(fail), 64'd0);
    check("rst_fcnt",  64'(fail_count), 64'd0);
    check("rst_vcnt",  64'(vec_count), 64'd0);
    check("rst_tsel",  64'(target_sel), 64'd0);
    check("rst_rdreq", 64'(fifo_if.sfifo_rdreq), 64'd0);
    check("rst_wrreq", 64'(fifo_if.rfifo_wrreq), 64'd0);
    check("rst_rdata", 64'(fifo_if.rfifo_data), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // CAPTURE, lane 2, cycles 0/3/31
    lane2_v = 24'hA5A5A5;
    push_vec(1'b0, 0,  24'h0, 24'h111111);
    push_vec(1'b0, 3,  24'h0, 24'h222222);
    push_vec(1'b1, 31, 24'h0, 24'h333333);
    rq.delete(); rd_idx.delete();
    d0 = done_cnt;
    run_start(MODE_CAPTURE, 2'd2, 24'h0);
    wait_done("t1_done", 300);
    check("t1_nres", 64'(rq.size()), 64'd3);
    for (int i = 0; i < 3; i++) check("t1_res", 64'(rq[i]), 64'(res(1'b0, cs[i], 24'hA5A5A5)));
    check("t1_vcnt", 64'(vec_count), 64'd3);
    check("t1_fail", 64'(fail), 64'd0);
    check("t1_tsel", 64'(target_sel), 64'd2);
    check("t1_mosi", 64'(mosi), 64'h333333);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_per0", 64'(rd_idx[1] - rd_idx[0]), 64'd4);
    check("t1_per1", 64'(rd_idx[2] - rd_idx[1]), 64'd7);
    tick(5);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);

    // Sampling edge: lane 3 carries the edge index, expect E+cycles+1
    push_vec(1'b0, 0,  24'h0, 24'h0A0001);
    push_vec(1'b0, 3,  24'h0, 24'h0A0002);
    push_vec(1'b1, 31, 24'h0, 24'h0A0003);
    rq.delete(); rd_idx.delete();
    run_start(MODE_CAPTURE, 2'd3, 24'h0);
    wait_done("t1b_done", 300);
    check("t1b_nres", 64'(rq.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check("t1b_edge", 64'(rq[i]), 64'(res(1'b0, cs[i], RTF'(rd_idx[i] + cs[i]))));

    // COMPARE with low-byte mask
    lane1_v = 24'hFFFFAB;
    push_vec(1'b0, 1, 24'h1234AB, 24'h000001);
    push_vec(1'b1, 2, 24'h0000AC, 24'h000002);
    rq.delete(); rd_idx.delete();
    run_start(MODE_COMPARE, 2'd1, 24'h0000FF);
    wait_done("t2_done", 100);
    check("t2_nres", 64'(rq.size()), 64'd2);
    check("t2_res0", 64'(rq[0]), 64'(res(1'b0, 1, 24'hFFFFAB)));
    check("t2_res1", 64'(rq[1]), 64'(res(1'b1, 2, 24'hFFFFAB)));
    check("t2_fail", 64'(fail), 64'd1);
    check("t2_fcnt", 64'(fail_count), 64'd1);
    check("t2_vcnt", 64'(vec_count), 64'd2);

    // Stimulus FIFO runs dry mid-test
    push_vec(1'b0, 2, 24'h0, 24'h444444);
    rq.delete(); rd_idx.delete();
    run_start(MODE_CAPTURE, 2'd2, 24'h0);
    check("t3_fail_clr", 64'(fail), 64'd0);
    check("t3_fcnt_clr", 64'(fail_count), 64'd0);
    n = 0;
    while (rq.size() < 1 && n < 50) begin tick(1); n++; end
    check("t3_first", 64'(rq.size()), 64'd1);
    tick(10);
    check("t3_no_rd", 64'(rd_idx.size()), 64'd1);
    check("t3_busy",  64'(busy), 64'd1);
    check("t3_mosi_hold", 64'(mosi), 64'h444444);
    push_vec(1'b1, 1, 24'h0, 24'h555555);
    wait_done("t3_done", 50);
    check("t3_mosi", 64'(mosi), 64'h555555);
    check("t3_nres", 64'(rq.size()), 64'd2);
    check("t3_res1", 64'(rq[1]), 64'(res(1'b0, 1, 24'hA5A5A5)));
    check("t3_vcnt", 64'(vec_count), 64'd2);

    // Result FIFO full at WRITE
    fifo_if.rfifo_wrfull = 1'b1;
    push_vec(1'b1, 1, 24'h0, 24'h666666);
    rq.delete(); rd_idx.delete();
    run_start(MODE_CAPTURE, 2'd2, 24'h0);
    tick(20);
    check("t4_no_wr", 64'(rq.size()), 64'd0);
    check("t4_busy",  64'(busy), 64'd1);
    fifo_if.rfifo_wrfull = 1'b0;
    wait_done("t4_done", 20);
    tick(10);
    check("t4_nres", 64'(rq.size()), 64'd1);
    check("t4_res",  64'(rq[0]), 64'(res(1'b0, 1, 24'hA5A5A5)));
    check("t4_vcnt", 64'(vec_count), 64'd1);

    // Abort during a long APPLY
    push_vec(1'b1, 20, 24'h0, 24'h777777);
    rq.delete(); rd_idx.delete();
    run_start(MODE_CAPTURE, 2'd2, 24'h0);
    n = 0;
    while (rd_idx.size() < 1 && n < 20) begin tick(1); n++; end
    check("t5_loaded", 64'(rd_idx.size()), 64'd1);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    d0 = done_cnt;
    tick(40);
    check("t5_no_wr",   64'(rq.size()), 64'd0);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    check("t5_vcnt",    64'(vec_count), 64'd0);
    push_vec(1'b1, 0, 24'h0, 24'h888888);
    run_start(MODE_CAPTURE, 2'd2, 24'h0);
    wait_done("t5_rerun_done", 50);
    check("t5_rerun_nres", 64'(rq.size()), 64'd1);
    check("t5_rerun_vcnt", 64'(vec_count), 64'd1);
    check("t5_rerun_mosi", 64'(mosi), 64'h888888);

    // Five vectors, mismatch on the second
    lane1_v = 24'hFFFFAB;
    push_vec(1'b0, 1, 24'hFFFFAB, 24'h000011);
    push_vec(1'b0, 1, 24'h000000, 24'h000012);
    push_vec(1'b0, 1, 24'hFFFFAB, 24'h000013);
    push_vec(1'b0, 1, 24'hFFFFAB, 24'h000014);
    push_vec(1'b1, 1, 24'hFFFFAB, 24'h000015);
    rq.delete(); rd_idx.delete();
    run_start(MODE_COMPARE, 2'd1, 24'hFFFFFF);
    wait_done("t6_done", 200);
    check("t6_res0", 64'(rq[0]), 64'(res(1'b0, 1, 24'hFFFFAB)));
    check("t6_res1", 64'(rq[1]), 64'(res(1'b1, 1, 24'hFFFFAB)));
    check("t6_fail", 64'(fail), 64'd1);
    check("t6_fcnt", 64'(fail_count), 64'd1);
`ifdef VECTOR_ENGINE_STOP_ON_FAIL_EN
    check("t6_nres", 64'(rq.size()), 64'd2);
    check("t6_left", 64'(sq.size()), 64'd3);
    check("t6_vcnt", 64'(vec_count), 64'd2);
    check("t6_mosi", 64'(mosi), 64'h000012);
`else
    check("t6_nres", 64'(rq.size()), 64'd5);
    check("t6_left", 64'(sq.size()), 64'd0);
    check("t6_vcnt", 64'(vec_count), 64'd5);
    check("t6_res4", 64'(rq[4]), 64'(res(1'b0, 1, 24'hFFFFAB)));
`endif
    sq.delete();
    tick(2);

    check("protocol", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
